// File: rtl/obi_xbar_periph_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : XBAR_PERIPH_BUS                                              |
// | Description : Peripheral crossbar bus, request plus unthrottled response.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface XBAR_PERIPH_BUS #(
    parameter int unsigned ID_WIDTH = 6
);
    logic                req;
    logic [31:0]         add;
    logic                wen;
    logic [31:0]         wdata;
    logic [3:0]          be;
    logic                gnt;
    logic [ID_WIDTH-1:0] id;
    logic                r_valid;
    logic                r_opc;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0]         r_rdata;

    modport Master (
        output req, add, wen, wdata, be, id,
        input  gnt, r_valid, r_opc, r_id, r_rdata
    );

    modport Slave (
        input  req, add, wen, wdata, be, id,
        output gnt, r_valid, r_opc, r_id, r_rdata
    );
endinterface
`default_nettype wire

// File: rtl/obi_xbar_periph_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : obi_xbar_periph_bridge                                       |
// | Description : OBI slave to XBAR_PERIPH_BUS master with credit-limited      |
// |               in-flight transactions and a buffered, in-order response.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module obi_xbar_periph_bridge #(
    parameter int unsigned ID_WIDTH  = 6,
    parameter int unsigned AID_WIDTH = 4,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [31:0]          obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [3:0]           obi_be_i,
    input  logic [31:0]          obi_wdata_i,
    input  logic [AID_WIDTH-1:0] obi_aid_i,
    output logic                 obi_rvalid_o,
    input  logic                 obi_rready_i,
    output logic [31:0]          obi_rdata_o,
    output logic                 obi_err_o,
    output logic [AID_WIDTH-1:0] obi_rid_o,
    XBAR_PERIPH_BUS.Master       periph_mst,
    output logic                 protocol_err_o
);

    localparam int unsigned       c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

    logic [c_CNT_W-1:0]   r_used;
    logic [ID_WIDTH-1:0]  r_issue_cnt;
    logic                 r_protocol_err;

    logic [AID_WIDTH-1:0] r_tag_aid [DEPTH];
    logic                 r_tag_we  [DEPTH];
    logic [ID_WIDTH-1:0]  r_tag_id  [DEPTH];
    logic [c_PTR_W-1:0]   r_tag_wr;
    logic [c_PTR_W-1:0]   r_tag_rd;
    logic [c_CNT_W-1:0]   r_tag_fill;

    logic [31:0]          r_rsp_rdata [DEPTH];
    logic                 r_rsp_err   [DEPTH];
    logic [AID_WIDTH-1:0] r_rsp_rid   [DEPTH];
    logic [c_PTR_W-1:0]   r_rsp_wr;
    logic [c_PTR_W-1:0]   r_rsp_rd;
    logic [c_CNT_W-1:0]   r_rsp_fill;

    logic w_can_issue;
    logic w_issue;
    logic w_rsp_valid;
    logic w_pop;
    logic w_capture;
    logic w_id_mismatch;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        w_can_issue   = (r_used < c_DEPTH) & ~rst_i;
        w_issue       = obi_req_i & periph_mst.gnt & w_can_issue;
        w_rsp_valid   = (r_rsp_fill != '0);
        w_pop         = w_rsp_valid & obi_rready_i;
        w_capture     = periph_mst.r_valid & (r_tag_fill != '0);
        w_id_mismatch = (periph_mst.r_id != r_tag_id[r_tag_rd]);
    end

    // Request path is purely combinational; XBAR uses an active-low write enable.
    always_comb begin
        periph_mst.req   = obi_req_i & w_can_issue;
        periph_mst.add   = obi_addr_i;
        periph_mst.wen   = ~obi_we_i;
        periph_mst.wdata = obi_wdata_i;
        periph_mst.be    = obi_be_i;
        periph_mst.id    = r_issue_cnt;
        obi_gnt_o        = periph_mst.gnt & w_can_issue;
    end

    always_comb begin
        obi_rvalid_o   = w_rsp_valid;
        obi_rdata_o    = w_rsp_valid ? r_rsp_rdata[r_rsp_rd] : '0;
        obi_err_o      = w_rsp_valid ? r_rsp_err[r_rsp_rd]   : 1'b0;
        obi_rid_o      = w_rsp_valid ? r_rsp_rid[r_rsp_rd]   : '0;
        protocol_err_o = r_protocol_err;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_used         <= '0;
            r_issue_cnt    <= '0;
            r_protocol_err <= 1'b0;
            r_tag_wr       <= '0;
            r_tag_rd       <= '0;
            r_tag_fill     <= '0;
            r_rsp_wr       <= '0;
            r_rsp_rd       <= '0;
            r_rsp_fill     <= '0;
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_used <= r_used + 1'b1;
                2'b01:   r_used <= r_used - 1'b1;
                default: r_used <= r_used;
            endcase

            case ({w_issue, w_capture})
                2'b10:   r_tag_fill <= r_tag_fill + 1'b1;
                2'b01:   r_tag_fill <= r_tag_fill - 1'b1;
                default: r_tag_fill <= r_tag_fill;
            endcase

            case ({w_capture, w_pop})
                2'b10:   r_rsp_fill <= r_rsp_fill + 1'b1;
                2'b01:   r_rsp_fill <= r_rsp_fill - 1'b1;
                default: r_rsp_fill <= r_rsp_fill;
            endcase

            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
                r_tag_wr    <= next_ptr(r_tag_wr);
            end
            if (w_capture) begin
                r_tag_rd <= next_ptr(r_tag_rd);
                r_rsp_wr <= next_ptr(r_rsp_wr);
            end
            if (w_pop) begin
                r_rsp_rd <= next_ptr(r_rsp_rd);
            end

            // A response with no outstanding tag, or with the wrong id, is a protocol violation.
            if (periph_mst.r_valid && ((r_tag_fill == '0) || w_id_mismatch)) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: fill counters alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_tag_aid[r_tag_wr] <= obi_aid_i;
            r_tag_we[r_tag_wr]  <= obi_we_i;
            r_tag_id[r_tag_wr]  <= r_issue_cnt;
        end
        if (w_capture) begin
            r_rsp_rdata[r_rsp_wr] <= r_tag_we[r_tag_rd] ? 32'h0 : periph_mst.r_rdata;
            r_rsp_err[r_rsp_wr]   <= periph_mst.r_opc | w_id_mismatch;
            r_rsp_rid[r_rsp_wr]   <= r_tag_aid[r_tag_rd];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_xbar_periph_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_obi_xbar_periph_bridge                                    |
// | Description : Directed bench for the OBI to XBAR_PERIPH_BUS bridge.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_obi_xbar_periph_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic [3:0]  obi_aid_i;
    logic        obi_rvalid_o;
    logic        obi_rready_i;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic [3:0]  obi_rid_o;
    logic        protocol_err_o;

    int n_checks = 0;
    int n_errors = 0;

    XBAR_PERIPH_BUS #(.ID_WIDTH(6)) periph ();

    obi_xbar_periph_bridge #(
        .ID_WIDTH  (6),
        .AID_WIDTH (4),
        .DEPTH     (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .obi_req_i      (obi_req_i),
        .obi_gnt_o      (obi_gnt_o),
        .obi_addr_i     (obi_addr_i),
        .obi_we_i       (obi_we_i),
        .obi_be_i       (obi_be_i),
        .obi_wdata_i    (obi_wdata_i),
        .obi_aid_i      (obi_aid_i),
        .obi_rvalid_o   (obi_rvalid_o),
        .obi_rready_i   (obi_rready_i),
        .obi_rdata_o    (obi_rdata_o),
        .obi_err_o      (obi_err_o),
        .obi_rid_o      (obi_rid_o),
        .periph_mst     (periph),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic rsp(input logic [5:0] id, input logic [31:0] data, input logic opc);
        periph.r_valid = 1'b1;
        periph.r_id    = id;
        periph.r_rdata = data;
        periph.r_opc   = opc;
    endtask

    initial begin
        rst_i          = 1'b1;
        obi_req_i      = 1'b0;
        obi_addr_i     = '0;
        obi_we_i       = 1'b0;
        obi_be_i       = 4'hF;
        obi_wdata_i    = '0;
        obi_aid_i      = '0;
        obi_rready_i   = 1'b1;
        periph.gnt     = 1'b0;
        periph.r_valid = 1'b0;
        periph.r_opc   = 1'b0;
        periph.r_id    = '0;
        periph.r_rdata = '0;

        // Reset values, with a pending request that must not leak through
        tick();
        tick();
        obi_req_i  = 1'b1;
        periph.gnt = 1'b1;
        settle();
        chk("rst_gnt",    {31'd0, obi_gnt_o},      32'd0);
        chk("rst_preq",   {31'd0, periph.req},     32'd0);
        chk("rst_rvalid", {31'd0, obi_rvalid_o},   32'd0);
        chk("rst_rdata",  obi_rdata_o,             32'd0);
        chk("rst_err",    {31'd0, obi_err_o},      32'd0);
        chk("rst_rid",    {28'd0, obi_rid_o},      32'd0);
        chk("rst_pid",    {26'd0, periph.id},      32'd0);
        chk("rst_perr",   {31'd0, protocol_err_o}, 32'd0);
        obi_req_i  = 1'b0;
        periph.gnt = 1'b0;
        rst_i      = 1'b0;
        tick();

        // T1: read
        obi_req_i  = 1'b1;
        obi_addr_i = 32'h100;
        obi_we_i   = 1'b0;
        obi_aid_i  = 4'd3;
        periph.gnt = 1'b1;
        settle();
        chk("t1_preq", {31'd0, periph.req}, 32'd1);
        chk("t1_add",  periph.add,          32'h100);
        chk("t1_wen",  {31'd0, periph.wen}, 32'd1);
        chk("t1_pid",  {26'd0, periph.id},  32'd0);
        chk("t1_gnt",  {31'd0, obi_gnt_o},  32'd1);
        tick();
        obi_req_i  = 1'b0;
        periph.gnt = 1'b0;
        tick();
        rsp(6'd0, 32'hDEADBEEF, 1'b0);
        settle();
        chk("t1_no_rvalid_yet", {31'd0, obi_rvalid_o}, 32'd0);
        tick();
        periph.r_valid = 1'b0;
        settle();
        chk("t1_rvalid", {31'd0, obi_rvalid_o}, 32'd1);
        chk("t1_rdata",  obi_rdata_o,           32'hDEADBEEF);
        chk("t1_rid",    {28'd0, obi_rid_o},    32'd3);
        chk("t1_err",    {31'd0, obi_err_o},    32'd0);
        tick();
        chk("t1_popped", {31'd0, obi_rvalid_o}, 32'd0);

        // T2: write, bus error reported but not a protocol error
        obi_req_i   = 1'b1;
        obi_we_i    = 1'b1;
        obi_wdata_i = 32'h5;
        obi_be_i    = 4'hF;
        obi_aid_i   = 4'd5;
        obi_addr_i  = 32'h104;
        periph.gnt  = 1'b1;
        settle();
        chk("t2_wen",   {31'd0, periph.wen}, 32'd0);
        chk("t2_wdata", periph.wdata,        32'h5);
        chk("t2_be",    {28'd0, periph.be},  32'hF);
        chk("t2_pid",   {26'd0, periph.id},  32'd1);
        tick();
        obi_req_i  = 1'b0;
        obi_we_i   = 1'b0;
        periph.gnt = 1'b0;
        rsp(6'd1, 32'h1234, 1'b1);
        tick();
        periph.r_valid = 1'b0;
        periph.r_opc   = 1'b0;
        settle();
        chk("t2_rvalid", {31'd0, obi_rvalid_o},   32'd1);
        chk("t2_rdata",  obi_rdata_o,             32'd0);
        chk("t2_err",    {31'd0, obi_err_o},      32'd1);
        chk("t2_rid",    {28'd0, obi_rid_o},      32'd5);
        chk("t2_perr",   {31'd0, protocol_err_o}, 32'd0);
        tick();

        // T3: credit limit, responses held back
        do_reset();
        obi_rready_i = 1'b0;
        obi_req_i    = 1'b1;
        periph.gnt   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            obi_aid_i = 4'(i);
            settle();
            chk("t3_gnt", {31'd0, obi_gnt_o}, 32'd1);
            chk("t3_pid", {26'd0, periph.id}, 32'(i));
            tick();
        end
        obi_aid_i = 4'd4;
        settle();
        chk("t3_full_gnt",  {31'd0, obi_gnt_o},  32'd0);
        chk("t3_full_preq", {31'd0, periph.req}, 32'd0);
        tick();

        // T4: three responses arrive while the OBI side stalls
        for (int i = 0; i < 3; i++) begin
            rsp(6'(i), 32'hA0 + 32'(i), 1'b0);
            tick();
            periph.r_valid = 1'b0;
            settle();
            chk("t4_hold_rvalid", {31'd0, obi_rvalid_o}, 32'd1);
            chk("t4_hold_rdata",  obi_rdata_o,           32'hA0);
            chk("t4_hold_rid",    {28'd0, obi_rid_o},    32'd0);
            chk("t4_hold_gnt",    {31'd0, obi_gnt_o},    32'd0);
        end
        obi_rready_i = 1'b1;
        tick();
        chk("t3_fifth_gnt", {31'd0, obi_gnt_o}, 32'd1);
        chk("t3_fifth_pid", {26'd0, periph.id}, 32'd4);
        chk("t4_rdata1",    obi_rdata_o,        32'hA1);
        chk("t4_rid1",      {28'd0, obi_rid_o}, 32'd1);
        tick();
        obi_req_i  = 1'b0;
        periph.gnt = 1'b0;
        settle();
        chk("t4_rdata2", obi_rdata_o,        32'hA2);
        chk("t4_rid2",   {28'd0, obi_rid_o}, 32'd2);
        tick();
        chk("t4_drained", {31'd0, obi_rvalid_o}, 32'd0);
        rsp(6'd3, 32'hA3, 1'b0);
        tick();
        periph.r_id    = 6'd4;
        periph.r_rdata = 32'hA4;
        settle();
        chk("t4_rdata3", obi_rdata_o,        32'hA3);
        chk("t4_rid3",   {28'd0, obi_rid_o}, 32'd3);
        tick();
        periph.r_valid = 1'b0;
        settle();
        chk("t4_rdata4", obi_rdata_o,             32'hA4);
        chk("t4_rid4",   {28'd0, obi_rid_o},      32'd4);
        chk("t4_err4",   {31'd0, obi_err_o},      32'd0);
        chk("t4_perr",   {31'd0, protocol_err_o}, 32'd0);
        tick();

        // T5: response id mismatch
        obi_req_i  = 1'b1;
        obi_aid_i  = 4'd7;
        periph.gnt = 1'b1;
        settle();
        chk("t5_pid", {26'd0, periph.id}, 32'd5);
        tick();
        obi_req_i  = 1'b0;
        periph.gnt = 1'b0;
        rsp(6'd7, 32'h55, 1'b0);
        tick();
        periph.r_valid = 1'b0;
        settle();
        chk("t5_err",   {31'd0, obi_err_o},      32'd1);
        chk("t5_rid",   {28'd0, obi_rid_o},      32'd7);
        chk("t5_rdata", obi_rdata_o,             32'h55);
        chk("t5_perr",  {31'd0, protocol_err_o}, 32'd1);
        tick();
        chk("t5_perr_sticky", {31'd0, protocol_err_o}, 32'd1);

        // T6: reset with two in flight, one of them already buffered
        do_reset();
        settle();
        chk("t6_perr_cleared", {31'd0, protocol_err_o}, 32'd0);
        obi_rready_i = 1'b0;
        obi_req_i    = 1'b1;
        periph.gnt   = 1'b1;
        obi_aid_i    = 4'd1;
        tick();
        obi_aid_i = 4'd2;
        tick();
        obi_req_i  = 1'b0;
        periph.gnt = 1'b0;
        rsp(6'd0, 32'h77, 1'b0);
        tick();
        periph.r_valid = 1'b0;
        settle();
        chk("t6_buffered", {31'd0, obi_rvalid_o}, 32'd1);
        rst_i      = 1'b1;
        obi_req_i  = 1'b1;
        periph.gnt = 1'b1;
        settle();
        chk("t6_rst_gnt", {31'd0, obi_gnt_o}, 32'd0);
        tick();
        rst_i      = 1'b0;
        obi_req_i  = 1'b0;
        periph.gnt = 1'b0;
        settle();
        chk("t6_rvalid", {31'd0, obi_rvalid_o},   32'd0);
        chk("t6_rdata",  obi_rdata_o,             32'd0);
        chk("t6_rid",    {28'd0, obi_rid_o},      32'd0);
        chk("t6_err",    {31'd0, obi_err_o},      32'd0);
        chk("t6_pid",    {26'd0, periph.id},      32'd0);
        chk("t6_perr",   {31'd0, protocol_err_o}, 32'd0);
        rsp(6'd1, 32'h88, 1'b0);
        tick();
        periph.r_valid = 1'b0;
        settle();
        chk("t6_late_perr",   {31'd0, protocol_err_o}, 32'd1);
        chk("t6_late_rvalid", {31'd0, obi_rvalid_o},   32'd0);

        // Credits fully restored: four fresh ids from zero, fifth held
        obi_req_i  = 1'b1;
        periph.gnt = 1'b1;
        obi_aid_i  = 4'd9;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t6_new_gnt", {31'd0, obi_gnt_o}, 32'd1);
            chk("t6_new_pid", {26'd0, periph.id}, 32'(i));
            tick();
        end
        settle();
        chk("t6_full_gnt", {31'd0, obi_gnt_o}, 32'd0);
        obi_req_i  = 1'b0;
        periph.gnt = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
